// File: rtl/signed_div_seq.sv
// signed_div_seq: sequential N-bit signed integer divider.
// Restoring division on operand magnitudes, one quotient bit per clock,
// followed by one sign-correction cycle. Division truncates toward zero.
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst          asynchronous active-high reset
//   i_start        start request, accepted only while o_busy=0
//   i_dividend     signed dividend, captured on accepted start
//   i_divisor      signed divisor, captured on accepted start
//   o_busy         high while a division is in progress
//   o_done         one-cycle pulse when results are valid
//   o_quotient     signed quotient, held until the next result
//   o_remainder    signed remainder, held until the next result
//   o_div_by_zero  divisor was zero (quotient all ones, remainder = dividend)
//   o_overflow     -2^(N-1) / -1 (quotient wraps to -2^(N-1))
module signed_div_seq #(
  parameter int N = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_quotient,
  output logic [N-1:0] o_remainder,
  output logic         o_div_by_zero,
  output logic         o_overflow
);

  localparam int CW = $clog2(N) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [N-1:0]  ONE     = N'(1);
  localparam logic [N-1:0]  MIN_MAG = {1'b1, {(N-1){1'b0}}};
  localparam logic [CW-1:0] CNT_TOP = CW'(N - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  dvd;
  logic [N-1:0]  dvd_mag;
  logic [N-1:0]  dvs_mag;
  logic          dvd_neg;
  logic          dvs_neg;
  logic [N-1:0]  rem;
  logic [N-1:0]  quo;

  logic          accept;
  logic [N-1:0]  dvd_mag_in;
  logic [N-1:0]  dvs_mag_in;
  logic [N:0]    shifted;
  logic [N:0]    trial;
  logic          div_zero;
  logic          ovf;

  assign accept = i_start && ((state == S_IDLE) || (state == S_DONE));

  // Magnitude as N-bit unsigned, so the most negative value maps to 2^(N-1).
  assign dvd_mag_in = i_dividend[N-1] ? (~i_dividend + ONE) : i_dividend;
  assign dvs_mag_in = i_divisor[N-1]  ? (~i_divisor + ONE)  : i_divisor;

  // quo initially holds the dividend magnitude; its MSB feeds the partial
  // remainder while quotient bits enter at the LSB.
  assign shifted = {rem, quo[N-1]};
  assign trial   = shifted - {1'b0, dvs_mag};

  assign div_zero = (dvs_mag == '0);
  assign ovf      = dvd_neg && dvs_neg && (dvd_mag == MIN_MAG) && (dvs_mag == ONE);

  assign o_busy = (state == S_CALC) || (state == S_FIX);
  assign o_done = (state == S_DONE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      dvd           <= '0;
      dvd_mag       <= '0;
      dvs_mag       <= '0;
      dvd_neg       <= 1'b0;
      dvs_neg       <= 1'b0;
      rem           <= '0;
      quo           <= '0;
      o_quotient    <= '0;
      o_remainder   <= '0;
      o_div_by_zero <= 1'b0;
      o_overflow    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            dvd           <= i_dividend;
            dvd_mag       <= dvd_mag_in;
            dvs_mag       <= dvs_mag_in;
            dvd_neg       <= i_dividend[N-1];
            dvs_neg       <= i_divisor[N-1];
            rem           <= '0;
            quo           <= dvd_mag_in;
            cnt           <= CNT_TOP;
            o_div_by_zero <= 1'b0;
            o_overflow    <= 1'b0;
            state         <= S_CALC;
          end else begin
            state <= S_IDLE;
          end
        end
        S_CALC: begin
          if (trial[N]) begin
            rem <= shifted[N-1:0];
          end else begin
            rem <= trial[N-1:0];
          end
          quo <= {quo[N-2:0], ~trial[N]};
          if (cnt == '0) begin
            state <= S_FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_FIX: begin
          if (div_zero) begin
            o_quotient  <= '1;
            o_remainder <= dvd;
          end else begin
            o_quotient  <= (dvd_neg ^ dvs_neg) ? (~quo + ONE) : quo;
            o_remainder <= dvd_neg ? (~rem + ONE) : rem;
          end
          o_div_by_zero <= div_zero;
          o_overflow    <= ovf && !div_zero;
          state         <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_div_seq.sv
// Scoreboard bench for signed_div_seq (N=4): the driver pushes expected
// results with their predicted completion cycle; a negedge monitor pops and
// compares on o_done and tracks o_busy against the outstanding operation.
module tb_signed_div_seq;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         dz;
  logic         ovf;

  signed_div_seq #(.N(N)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_dividend   (dividend),
    .i_divisor    (divisor),
    .o_busy       (busy),
    .o_done       (done),
    .o_quotient   (quotient),
    .o_remainder  (remainder),
    .o_div_by_zero(dz),
    .o_overflow   (ovf)
  );

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
    logic         ov;
    int           start_cyc;
    int           done_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   next_accept = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Truncating reference, used for generated vectors.
  task automatic ref_div(input int a, input int b, output logic [N-1:0] q,
                         output logic [N-1:0] r, output logic z, output logic o);
    int qi;
    int ri;
    z = 1'b0;
    o = 1'b0;
    if (b == 0) begin
      qi = -1;
      ri = a;
      z  = 1'b1;
    end else if (a == -(1 << (N - 1)) && b == -1) begin
      qi = a;
      ri = 0;
      o  = 1'b1;
    end else begin
      qi = a / b;
      ri = a % b;
    end
    q = qi[N-1:0];
    r = ri[N-1:0];
  endtask

  // Called at a negedge where a start is being presented for the next edge.
  task automatic push_exp(input logic [N-1:0] q, input logic [N-1:0] r,
                          input logic z, input logic o);
    exp_t e;
    e.q         = q;
    e.r         = r;
    e.dz        = z;
    e.ov        = o;
    e.start_cyc = cyc + 1;
    e.done_cyc  = cyc + 1 + N + 1;
    sb.push_back(e);
    next_accept = cyc + 1 + N + 2;
  endtask

  task automatic issue(input int a, input int b, input logic [N-1:0] q,
                       input logic [N-1:0] r, input logic z, input logic o);
    @(negedge clk);
    while (cyc + 1 < next_accept) @(negedge clk);
    dividend = a[N-1:0];
    divisor  = b[N-1:0];
    start    = 1'b1;
    push_exp(q, r, z, o);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic issue_ref(input int a, input int b);
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic z;
    logic o;
    ref_div(a, b, q, r, z, o);
    issue(a, b, q, r, z, o);
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    logic exp_busy;
    if (!rst) begin
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.done_cyc);
          chk("quotient", int'(quotient), int'(e.q));
          chk("remainder", int'(remainder), int'(e.r));
          chk("div_by_zero", int'(dz), int'(e.dz));
          chk("overflow", int'(ovf), int'(e.ov));
        end
      end else if (sb.size() > 0 && cyc >= sb[0].done_cyc) begin
        chk("done_timeout", 0, 1);
        void'(sb.pop_front());
      end
      exp_busy = (sb.size() > 0) && (cyc >= sb[0].start_cyc) && (cyc < sb[0].done_cyc);
      chk("busy", int'(busy), int'(exp_busy));
    end
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_q", int'(quotient), 0);
    chk("rst_r", int'(remainder), 0);
    chk("rst_flags", int'({dz, ovf}), 0);
    rst = 1'b0;

    // Sign matrix and boundaries (hand-computed)
    issue( 7,  2, 4'd3,    4'd1,    1'b0, 1'b0);
    issue(-7,  2, 4'b1101, 4'b1111, 1'b0, 1'b0);
    issue( 7, -2, 4'b1101, 4'd1,    1'b0, 1'b0);
    issue(-7, -2, 4'd3,    4'b1111, 1'b0, 1'b0);
    issue(-8, -1, 4'b1000, 4'd0,    1'b0, 1'b1);
    issue(-8,  1, 4'b1000, 4'd0,    1'b0, 1'b0);
    issue( 0,  5, 4'd0,    4'd0,    1'b0, 1'b0);
    issue( 3,  7, 4'd0,    4'd3,    1'b0, 1'b0);
    issue( 5,  0, 4'hF,    4'd5,    1'b1, 1'b0);
    issue( 4,  2, 4'd2,    4'd0,    1'b0, 1'b0);
    issue(-8,  0, 4'hF,    4'b1000, 1'b1, 1'b0);
    issue( 7, -8, 4'd0,    4'd7,    1'b0, 1'b0);

    // Reset in the second CALC cycle
    issue(7, 2, 4'd3, 4'd1, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_q", int'(quotient), 0);
    chk("midrst_r", int'(remainder), 0);
    chk("midrst_flags", int'({dz, ovf}), 0);
    @(negedge clk);
    rst = 1'b0;
    next_accept = 0;
    repeat (10) @(negedge clk);
    issue(6, 3, 4'd2, 4'd0, 1'b0, 1'b0);

    // i_start held high with operands changing every cycle
    @(negedge clk);
    while (cyc + 1 < next_accept) @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 30; k++) begin
      int a;
      int b;
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic z;
      logic o;
      if (k > 0) @(negedge clk);
      a = ((k * 5) % 16) - 8;
      b = ((k * 3 + 1) % 16) - 8;
      dividend = a[N-1:0];
      divisor  = b[N-1:0];
      if (cyc + 1 >= next_accept) begin
        ref_div(a, b, q, r, z, o);
        push_exp(q, r, z, o);
      end
    end
    @(posedge clk);
    #1 start = 1'b0;

    // Exhaustive sweep
    for (int a = -8; a < 8; a++) begin
      for (int b = -8; b < 8; b++) begin
        issue_ref(a, b);
      end
    end

    for (int w = 0; w < 100 && sb.size() > 0; w++) @(negedge clk);
    if (sb.size() > 0) chk("drain_timeout", sb.size(), 0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
